// File: rtl/pcieifc_sram_fifo_pkg.sv
// Shared widths and SRAM timing constants for the PCIe interface SRAM FIFO.
package pcieifc_sram_fifo_pkg;

  // Registered read latency of the external dual-port macro, in cycles.
  localparam int SRAM_RD_LAT = 1;

  // The output buffer must cover every word that can be in flight plus the head.
  localparam int OBUF_DEPTH = SRAM_RD_LAT + 1;

  // Width of a 0..DEPTH SRAM occupancy counter.
  function automatic int ptr_cnt_w(input int aw);
    return aw + 1;
  endfunction

  // Width of the total occupancy (SRAM + in-flight + output buffer, up to DEPTH+2).
  function automatic int total_cnt_w(input int aw);
    return aw + 2;
  endfunction

endpackage

// File: rtl/pcieifc_fwft_obuf.sv
// Two-entry first-word-fall-through output buffer that absorbs SRAM read data.
module pcieifc_fwft_obuf #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cap_vld,
  input  logic [DATAWIDTH-1:0] cap_data,
  input  logic                 rd_en,
  output logic                 pop,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 empty,
  output logic [1:0]           buf_cnt
);

  logic [DATAWIDTH-1:0] head_q, head_d;
  logic [DATAWIDTH-1:0] tail_q, tail_d;
  logic [1:0]           cnt_q, cnt_d;

  always_comb begin
    pop    = rd_en & (cnt_q != 2'd0);
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop) begin
      if (cnt_q == 2'd2) head_d = tail_q;
      cnt_d = cnt_q - 2'd1;
    end
    // Arriving data lands behind whatever survives this cycle's pop.
    if (cap_vld) begin
      if (cnt_d == 2'd0) head_d = cap_data;
      else               tail_d = cap_data;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout    = head_q;
  assign empty   = (cnt_q == 2'd0);
  assign buf_cnt = cnt_q;

endmodule

// File: rtl/pcieifc_sram_fifo.sv
// FWFT FIFO controller over an external true dual-port SRAM: port A writes, port B reads.
// Push handshake: a word is taken when wr_en=1 and full=0; pop: dout consumed when rd_en=1 and empty=0.
module pcieifc_sram_fifo
  import pcieifc_sram_fifo_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 6,
  parameter int DEPTH     = 1 << ADDRWIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_en,
  input  logic [DATAWIDTH-1:0]                 din,
  output logic                                 full,
  input  logic                                 rd_en,
  output logic [DATAWIDTH-1:0]                 dout,
  output logic                                 empty,
  output logic [total_cnt_w(ADDRWIDTH)-1:0]    count,
  output logic                                 err_ovf,
  output logic                                 err_udf,
  output logic                                 sram_wea,
  output logic [ADDRWIDTH-1:0]                 sram_addra,
  output logic [DATAWIDTH-1:0]                 sram_dina,
  output logic                                 sram_web,
  output logic [ADDRWIDTH-1:0]                 sram_addrb,
  output logic [DATAWIDTH-1:0]                 sram_dinb,
  input  logic [DATAWIDTH-1:0]                 sram_doutb
);

  localparam int CW = ptr_cnt_w(ADDRWIDTH);
  localparam int TW = total_cnt_w(ADDRWIDTH);

  logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        sram_cnt_q, sram_cnt_d;
  logic                 inflight_q, inflight_d;
  logic                 full_q, full_d;
  logic                 err_ovf_q, err_ovf_d;
  logic                 err_udf_q, err_udf_d;
  logic                 push, issue, pop, ob_empty;
  logic [1:0]           buf_cnt;
  logic [2:0]           occ;

  always_comb begin
    push = wr_en & ~full_q;
    // Slots that will still be claimed after this cycle's pop.
    occ   = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    issue = (sram_cnt_q != '0) && (occ < 3'(OBUF_DEPTH));
    wr_ptr_d   = wr_ptr_q + ADDRWIDTH'(push);
    rd_ptr_d   = rd_ptr_q + ADDRWIDTH'(issue);
    sram_cnt_d = sram_cnt_q + CW'(push) - CW'(issue);
    inflight_d = issue;
    full_d     = (sram_cnt_d == CW'(DEPTH));
    err_ovf_d  = wr_en & full_q;
    err_udf_d  = rd_en & ob_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      inflight_q <= 1'b0;
      full_q     <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_udf_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= inflight_d;
      full_q     <= full_d;
      err_ovf_q  <= err_ovf_d;
      err_udf_q  <= err_udf_d;
    end
  end

  pcieifc_fwft_obuf #(
    .DATAWIDTH (DATAWIDTH)
  ) u_obuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_vld  (inflight_q),
    .cap_data (sram_doutb),
    .rd_en    (rd_en),
    .pop      (pop),
    .dout     (dout),
    .empty    (ob_empty),
    .buf_cnt  (buf_cnt)
  );

  assign full       = full_q;
  assign empty      = ob_empty;
  assign count      = TW'(sram_cnt_q) + TW'(inflight_q) + TW'(buf_cnt);
  assign err_ovf    = err_ovf_q;
  assign err_udf    = err_udf_q;
  assign sram_wea   = push;
  assign sram_addra = wr_ptr_q;
  assign sram_dina  = din;
  assign sram_web   = 1'b0;
  assign sram_addrb = rd_ptr_q;
  assign sram_dinb  = '0;

endmodule

// File: tb/tb_pcieifc_sram_fifo.sv
// Directed self-checking bench for pcieifc_sram_fifo with a behavioural 64x32 dual-port SRAM.
module tb_pcieifc_sram_fifo;

  localparam int DW = 32;
  localparam int AW = 6;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          full;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          empty;
  logic [AW+1:0] count;
  logic          err_ovf;
  logic          err_udf;
  logic          sram_wea;
  logic [AW-1:0] sram_addra;
  logic [DW-1:0] sram_dina;
  logic          sram_web;
  logic [AW-1:0] sram_addrb;
  logic [DW-1:0] sram_dinb;
  logic [DW-1:0] sram_doutb;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w;
  int            n_cmp;
  int            n_fail;
  int            nxt;

  pcieifc_sram_fifo #(
    .DATAWIDTH (DW),
    .ADDRWIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .din        (din),
    .full       (full),
    .rd_en      (rd_en),
    .dout       (dout),
    .empty      (empty),
    .count      (count),
    .err_ovf    (err_ovf),
    .err_udf    (err_udf),
    .sram_wea   (sram_wea),
    .sram_addra (sram_addra),
    .sram_dina  (sram_dina),
    .sram_web   (sram_web),
    .sram_addrb (sram_addrb),
    .sram_dinb  (sram_dinb),
    .sram_doutb (sram_doutb)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // external SRAM: write on port A, registered read on port B
  always @(posedge clk) begin
    if (sram_wea) mem[sram_addra] <= sram_dina;
    sram_doutb <= mem[sram_addrb];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    do_reset();

    // reset state
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_dout", dout, 0);
    check("rst_ovf", err_ovf, 0);
    check("rst_udf", err_udf, 0);
    check("rst_wea", sram_wea, 0);
    check("rst_web", sram_web, 0);
    check("rst_dinb", sram_dinb, 0);

    // underflow right after reset
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("udf_pulse", err_udf, 1);
    check("udf_count", count, 0);
    check("udf_dout", dout, 0);
    check("udf_empty", empty, 1);
    tick();
    check("udf_clear", err_udf, 0);

    // first-word latency: push in cycle 0, visible in cycle 3
    check("lat_c0_empty", empty, 1);
    wr_en = 1'b1;
    din   = 32'hA5A5_0001;
    #1;
    check("lat_wea", sram_wea, 1);
    check("lat_addra", sram_addra, 0);
    check("lat_dina", sram_dina, 32'hA5A5_0001);
    tick();
    wr_en = 1'b0;
    check("lat_c1_empty", empty, 1);
    check("lat_c1_count", count, 1);
    tick();
    check("lat_c2_empty", empty, 1);
    tick();
    check("lat_c3_empty", empty, 0);
    check("lat_c3_dout", dout, 32'hA5A5_0001);
    check("lat_c3_count", count, 1);

    // pop in cycle 3 with a simultaneous push: count stays 1
    rd_en = 1'b1;
    wr_en = 1'b1;
    din   = 32'h0BAD_0002;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("pp_c4_count", count, 1);
    check("pp_c4_empty", empty, 1);
    tick();
    tick();
    check("pp_c6_empty", empty, 0);
    check("pp_c6_dout", dout, 32'h0BAD_0002);
    check("pp_c6_count", count, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pp_c7_empty", empty, 1);
    check("pp_c7_count", count, 0);

    // fill: 64 words in SRAM plus 2 in the output buffer
    do_reset();
    for (int i = 0; i < 66; i++) begin
      if (i == 65) check("fill_not_full", full, 0);
      wr_en = 1'b1;
      din   = 32'(i);
      exp_q.push_back(32'(i));
      tick();
    end
    // wr_en stays high: this is the rejected push
    din = 32'h0000_03E7;
    check("fill_full", full, 1);
    check("fill_count", count, 66);
    #1;
    check("ovf_wea", sram_wea, 0);
    tick();
    wr_en = 1'b0;
    check("ovf_pulse", err_ovf, 1);
    check("ovf_count", count, 66);
    check("ovf_full", full, 1);
    tick();
    check("ovf_clear", err_ovf, 0);

    // stream: pop every cycle, push a new word every cycle once room exists
    nxt = 66;
    for (int k = 0; k < 200; k++) begin
      exp_w = exp_q.pop_front();
      check($sformatf("stream_empty_%0d", k), empty, 0);
      check($sformatf("stream_dout_%0d", k), dout, exp_w);
      if (k >= 1) check($sformatf("stream_full_%0d", k), full, 0);
      rd_en = 1'b1;
      if (k >= 1 && nxt < 200) begin
        wr_en = 1'b1;
        din   = 32'(nxt);
        exp_q.push_back(32'(nxt));
        nxt++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);
    check("drain_udf", err_udf, 0);
    check("drain_ovf", err_ovf, 0);

    // reset mid-operation with a read in flight
    do_reset();
    for (int i = 0; i < 30; i++) begin
      wr_en = 1'b1;
      din   = 32'h100 + 32'(i);
      tick();
    end
    wr_en = 1'b0;
    repeat (3) tick();
    check("mid_count", count, 30);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty", empty, 1);
    check("mid_rst_count", count, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_dout", dout, 0);
    #2;
    rst_n = 1'b1;
    tick();
    wr_en = 1'b1;
    din   = 32'h0000_1234;
    tick();
    wr_en = 1'b0;
    tick();
    check("post_c2_empty", empty, 1);
    tick();
    check("post_c3_empty", empty, 0);
    check("post_c3_dout", dout, 32'h0000_1234);
    check("post_c3_count", count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
